// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder shared by two valid/ready requesters.
// A single 4-bit ripple slice is reused once per nibble, with the carry kept in a register.

module Adder4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = ci_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = carry[4];
  end

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req0_ci_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic             req1_ci_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_co_o,
  output logic             res_id_o
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             id_q;

  logic             grant0_d;
  logic             grant1_d;
  logic [3:0]       nib_a_d;
  logic [3:0]       nib_b_d;
  logic [3:0]       nib_s;
  logic             nib_co;

  // Round-robin: on a tie, the requester that was not served last wins.
  assign grant0_d = req0_valid_i & (~req1_valid_i | last_grant_q);
  assign grant1_d = req1_valid_i & ~grant0_d;

  assign req0_ready_o = (state_q == IDLE) & ~rst_i & grant0_d;
  assign req1_ready_o = (state_q == IDLE) & ~rst_i & grant1_d;

  assign res_valid_o = (state_q == DONE);
  assign res_sum_o   = sum_q;
  assign res_co_o    = co_q;
  assign res_id_o    = id_q;

  always_comb begin
    nib_a_d = a_q[3:0];
    nib_b_d = b_q[3:0];
    for (int n = 0; n < NIB; n++) begin
      if (int'(idx_q) == n) begin
        nib_a_d = a_q[n*4 +: 4];
        nib_b_d = b_q[n*4 +: 4];
      end
    end
  end

  Adder4b u_adder (
    .a_i (nib_a_d),
    .b_i (nib_b_d),
    .ci_i(carry_q),
    .s_o (nib_s),
    .co_o(nib_co)
  );

  // Reset abandons any operation in flight; nothing is reported for it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      co_q         <= 1'b0;
      id_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            a_q     <= grant1_d ? req1_a_i : req0_a_i;
            b_q     <= grant1_d ? req1_b_i : req0_b_i;
            carry_q <= grant1_d ? req1_ci_i : req0_ci_i;
            id_q    <= grant1_d;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (int'(idx_q) == n) sum_q[n*4 +: 4] <= nib_s;
          end
          carry_q <= nib_co;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            co_q    <= nib_co;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            last_grant_q <= id_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: scoreboard of expected sums filled at
// each accept, drained when a result appears; a second WIDTH=4 instance covers NIB=1.

module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_ci;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_ci;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_co, res_id;
  logic [15:0] res_sum;

  logic        w4_req0_valid, w4_req0_ready, w4_req0_ci;
  logic [3:0]  w4_req0_a, w4_req0_b;
  logic        w4_req1_ready;
  logic        w4_res_valid, w4_res_co, w4_res_id;
  logic [3:0]  w4_res_sum;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        id;
  } exp_t;

  exp_t sbq[$];
  exp_t lastExp;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   acceptCycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req0_ci_i   (req0_ci),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .req1_ci_i   (req1_ci),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_co_o    (res_co),
    .res_id_o    (res_id)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_valid_i(w4_req0_valid),
    .req0_ready_o(w4_req0_ready),
    .req0_a_i    (w4_req0_a),
    .req0_b_i    (w4_req0_b),
    .req0_ci_i   (w4_req0_ci),
    .req1_valid_i(1'b0),
    .req1_ready_o(w4_req1_ready),
    .req1_a_i    (4'h0),
    .req1_b_i    (4'h0),
    .req1_ci_i   (1'b0),
    .res_valid_o (w4_res_valid),
    .res_ready_i (1'b1),
    .res_sum_o   (w4_res_sum),
    .res_co_o    (w4_res_co),
    .res_id_o    (w4_res_id)
  );

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic id);
    logic [16:0] full;
    exp_t        r;
    full  = {1'b0, a} + {1'b0, b} + {16'h0, ci};
    r.sum = full[15:0];
    r.co  = full[16];
    r.id  = id;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input logic id, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic ci);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ci = ci;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ci = ci;
    end
  endtask

  // Waits for an accept, checks who won and how soon, and records the expected result.
  task automatic applyStimulus(input logic expId, input int expWait, input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) seen = 1'b1;
    end
    check({tag, " grant seen"}, seen, 1);
    if (seen) begin
      check({tag, " ready0"}, req0_ready, !expId);
      check({tag, " ready1"}, req1_ready, expId);
      if (expWait > 0) check({tag, " grant wait"}, n, expWait);
      acceptCycle = cycle;
      sbq.push_back(expId ? model(req1_a, req1_b, req1_ci, 1'b1)
                          : model(req0_a, req0_b, req0_ci, 1'b0));
    end
  endtask

  task automatic checkOutput(input int expLat, input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (res_valid) seen = 1'b1;
    end
    check({tag, " res_valid seen"}, seen, 1);
    if (seen) begin
      if (expLat > 0) check({tag, " latency"}, cycle - acceptCycle - 1, expLat);
      check({tag, " readies in DONE"}, {req0_ready, req1_ready}, 2'b00);
      check({tag, " scoreboard nonempty"}, sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        lastExp = sbq.pop_front();
        check({tag, " sum"}, res_sum, lastExp.sum);
        check({tag, " co"}, res_co, lastExp.co);
        check({tag, " id"}, res_id, lastExp.id);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    setReq(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    setReq(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0);
    w4_req0_valid = 1'b0; w4_req0_a = 4'h0; w4_req0_b = 4'h0; w4_req0_ci = 1'b0;

    // Reset values, with req0 already asking.
    repeat (2) @(negedge clk);
    check("rst ready0", req0_ready, 0);
    check("rst ready1", req1_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst sum", res_sum, 0);
    check("rst co", res_co, 0);
    check("rst id", res_id, 0);
    @(posedge clk); #1 rst = 1'b0;

    applyStimulus(1'b0, 1, "basic");
    @(posedge clk); #1 setReq(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    checkOutput(4, "basic");

    // Carry ripple through every nibble, req1 alone each time.
    setReq(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(1'b1, 1, "carry1");
    @(posedge clk); #1 setReq(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput(4, "carry1");
    setReq(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1, "carry2");
    @(posedge clk); #1 setReq(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput(4, "carry2");
    setReq(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    applyStimulus(1'b1, 1, "carry3");
    @(posedge clk); #1 setReq(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput(4, "carry3");

    // Round-robin from reset with both requesters held valid.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    setReq(1'b0, 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    setReq(1'b1, 1'b1, 16'hABCD, 16'h1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k[0], 1, $sformatf("arb%0d", k));
      checkOutput(4, $sformatf("arb%0d", k));
    end

    // Backpressure: result held for 10 cycles, no grants meanwhile.
    applyStimulus(1'b0, 1, "bp");
    res_ready = 1'b0;
    checkOutput(4, "bp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp hold valid", res_valid, 1);
      check("bp hold sum", res_sum, lastExp.sum);
      check("bp hold co/id", {res_co, res_id}, {lastExp.co, lastExp.id});
      check("bp hold readies", {req0_ready, req1_ready}, 2'b00);
    end
    res_ready = 1'b1;
    applyStimulus(1'b1, 1, "bp next");
    checkOutput(4, "bp next");

    // Reset during RUN at idx=2 abandons the operation.
    applyStimulus(1'b0, 1, "rstrun");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstrun readies in RUN", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    check("rstrun res_valid", res_valid, 0);
    check("rstrun sum", res_sum, 0);
    check("rstrun co/id", {res_co, res_id}, 2'b00);
    check("rstrun readies", {req0_ready, req1_ready}, 2'b00);
    sbq.delete();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1'b0, 1, "after rst");
    checkOutput(4, "after rst");
    setReq(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    setReq(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

    // WIDTH=4 instance: single-nibble operation.
    @(posedge clk);
    #1 begin
      w4_req0_valid = 1'b1; w4_req0_a = 4'h9; w4_req0_b = 4'h8; w4_req0_ci = 1'b1;
    end
    begin
      int   n = 0;
      logic seen = 1'b0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (w4_req0_ready) seen = 1'b1;
      end
      check("w4 grant seen", seen, 1);
      acceptCycle = cycle;
      @(posedge clk); #1 w4_req0_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (w4_res_valid) seen = 1'b1;
      end
      check("w4 res_valid seen", seen, 1);
      check("w4 latency", cycle - acceptCycle - 1, 1);
      check("w4 sum", w4_res_sum, 4'h2);
      check("w4 co/id", {w4_res_co, w4_res_id}, 2'b10);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
